// File: rtl/pwm_deadtime_fault_ctrl.sv
// Per-channel PWM output stage: splits one raw PWM into complementary high/low
// drives with a programmable dead band, and forces both low on a filtered fault.
module pwm_deadtime_fault_ctrl #(
   parameter int DT_W       = 8,
   parameter int FLT_SYNC   = 2,
   parameter int FLT_FILT_W = 4
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_i,
   input  logic                  en,
   input  logic                  pwm_in,
   input  logic [DT_W-1:0]       dead_time,
   input  logic                  fault_in,
   input  logic                  fault_pol,
   input  logic [FLT_FILT_W-1:0] flt_filt,
   input  logic                  fault_clr,
   input  logic                  auto_restart,
   output logic                  pwm0,
   output logic                  pwm1,
   output logic                  fault_o,
   output logic                  fault_irq,
   output logic [2:0]            state_o
);

   typedef enum logic [2:0] {
      ST_OFF   = 3'd0,
      ST_DT    = 3'd1,
      ST_HI    = 3'd2,
      ST_LO    = 3'd3,
      ST_FAULT = 3'd4
   } state_t;

   state_t                state_r;
   state_t                state_nxt_s;
   state_t                phase_s;
   logic [FLT_SYNC-1:0]   sync_r;
   logic [FLT_FILT_W-1:0] filt_cnt_r;
   logic [FLT_FILT_W-1:0] filt_max_s;
   logic [DT_W-1:0]       dt_cnt_r;
   logic                  flt_active_s;
   logic                  fault_det_s;
   logic                  dt_load_s;

   // A zero filter setting behaves like one sample; >= keeps detection sane
   // when flt_filt is lowered below a count already reached.
   assign filt_max_s   = (flt_filt == {FLT_FILT_W{1'b0}}) ? FLT_FILT_W'(1'b1) : flt_filt;
   assign flt_active_s = fault_pol ? sync_r[FLT_SYNC-1] : ~sync_r[FLT_SYNC-1];
   assign fault_det_s  = (filt_cnt_r >= filt_max_s);
   assign phase_s      = pwm_in ? ST_HI : ST_LO;

   // Fault pad synchronizer and saturating consecutive-sample filter
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         sync_r     <= {FLT_SYNC{1'b0}};
         filt_cnt_r <= {FLT_FILT_W{1'b0}};
      end else begin
         sync_r <= {sync_r[FLT_SYNC-2:0], fault_in};
         if (!flt_active_s) begin
            filt_cnt_r <= {FLT_FILT_W{1'b0}};
         end else if (filt_cnt_r >= filt_max_s) begin
            filt_cnt_r <= filt_max_s;
         end else begin
            filt_cnt_r <= filt_cnt_r + FLT_FILT_W'(1'b1);
         end
      end
   end

   // Next-state decode; fault has top priority, then fault exit, then enable
   always_comb begin
      state_nxt_s = state_r;
      dt_load_s   = 1'b0;
      if (fault_det_s && (state_r != ST_FAULT)) begin
         state_nxt_s = ST_FAULT;
      end else if (state_r == ST_FAULT) begin
         if (!fault_det_s && (fault_clr || auto_restart)) begin
            state_nxt_s = ST_OFF;
         end else begin
            state_nxt_s = ST_FAULT;
         end
      end else if (!en) begin
         state_nxt_s = ST_OFF;
      end else begin
         case (state_r)
            ST_OFF, ST_HI, ST_LO: begin
               // Entering from OFF or leaving a phase both start a dead band
               if ((state_r == ST_OFF) || (state_r != phase_s)) begin
                  if (dead_time == {DT_W{1'b0}}) begin
                     state_nxt_s = phase_s;
                  end else begin
                     state_nxt_s = ST_DT;
                     dt_load_s   = 1'b1;
                  end
               end else begin
                  state_nxt_s = state_r;
               end
            end
            ST_DT: begin
               if (dt_cnt_r <= DT_W'(1'b1)) begin
                  state_nxt_s = phase_s;
               end else begin
                  state_nxt_s = ST_DT;
               end
            end
            default: begin
               state_nxt_s = ST_OFF;
            end
         endcase
      end
   end

   // State, dead-band counter and outputs registered from next-state decode
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_r   <= ST_OFF;
         dt_cnt_r  <= {DT_W{1'b0}};
         pwm0      <= 1'b0;
         pwm1      <= 1'b0;
         fault_o   <= 1'b0;
         fault_irq <= 1'b0;
         state_o   <= 3'd0;
      end else begin
         state_r <= state_nxt_s;
         if (dt_load_s) begin
            dt_cnt_r <= dead_time;
         end else if (state_r == ST_DT) begin
            dt_cnt_r <= dt_cnt_r - DT_W'(1'b1);
         end else begin
            dt_cnt_r <= dt_cnt_r;
         end
         pwm0      <= (state_nxt_s == ST_HI);
         pwm1      <= (state_nxt_s == ST_LO);
         fault_o   <= (state_nxt_s == ST_FAULT);
         fault_irq <= (state_nxt_s == ST_FAULT) && (state_r != ST_FAULT);
         state_o   <= state_nxt_s;
      end
   end

endmodule

// File: tb/tb_pwm_deadtime_fault_ctrl.sv
// Bench for pwm_deadtime_fault_ctrl: directed scenarios plus random stimulus,
// every cycle scored against a timestamp-based behavioural model.
module tb_pwm_deadtime_fault_ctrl;

   localparam int DT_W       = 8;
   localparam int FLT_SYNC   = 2;
   localparam int FLT_FILT_W = 4;
   localparam int M_OFF = 0, M_DT = 1, M_HI = 2, M_LO = 3, M_FAULT = 4;

   logic                  clk = 1'b0;
   logic                  wb_rst_i;
   logic                  en;
   logic                  pwm_in;
   logic [DT_W-1:0]       dead_time;
   logic                  fault_in;
   logic                  fault_pol;
   logic [FLT_FILT_W-1:0] flt_filt;
   logic                  fault_clr;
   logic                  auto_restart;
   logic                  pwm0;
   logic                  pwm1;
   logic                  fault_o;
   logic                  fault_irq;
   logic [2:0]            state_o;

   always #5 clk = ~clk;

   pwm_deadtime_fault_ctrl #(
      .DT_W(DT_W), .FLT_SYNC(FLT_SYNC), .FLT_FILT_W(FLT_FILT_W)
   ) dut (
      .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .en(en), .pwm_in(pwm_in),
      .dead_time(dead_time), .fault_in(fault_in), .fault_pol(fault_pol),
      .flt_filt(flt_filt), .fault_clr(fault_clr), .auto_restart(auto_restart),
      .pwm0(pwm0), .pwm1(pwm1), .fault_o(fault_o), .fault_irq(fault_irq),
      .state_o(state_o)
   );

   typedef struct {
      logic       pwm0;
      logic       pwm1;
      logic       fo;
      logic       irq;
      logic [2:0] st;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model: mode, the edge number at which a dead band ends,
   // the current run of active synchronized fault samples, and the pad delay line.
   int   m_mode     = M_OFF;
   int   m_band_end = 0;
   int   m_run      = 0;
   int   m_edge     = 0;
   bit   m_dl[$];

   function automatic void chk(string name, int act, int want);
      total++;
      if (act != want) begin
         bad++;
         $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, act, want);
      end
   endfunction

   function automatic void model_enter();
      if (dead_time == 0) begin
         m_mode = pwm_in ? M_HI : M_LO;
      end else begin
         m_mode     = M_DT;
         m_band_end = m_edge + int'(dead_time);
      end
   endfunction

   // Predicts the outputs after the coming edge from the inputs now applied
   function automatic void model_step();
      exp_t e;
      int   prev;
      int   fmax;
      bit   det;
      bit   s;
      m_edge++;
      fmax = (flt_filt == 0) ? 1 : int'(flt_filt);
      if (wb_rst_i) begin
         m_mode = M_OFF;
         m_run  = 0;
         m_dl.delete();
         for (int i = 0; i < FLT_SYNC; i++) m_dl.push_back(1'b0);
         e.irq = 1'b0;
      end else begin
         det = (m_run >= fmax);
         s = m_dl.pop_front();
         m_dl.push_back(fault_in);
         if (s == fault_pol) m_run = (m_run < 1000) ? m_run + 1 : m_run;
         else m_run = 0;
         prev = m_mode;
         if (det && m_mode != M_FAULT) m_mode = M_FAULT;
         else if (m_mode == M_FAULT) begin
            if (!det && (fault_clr || auto_restart)) m_mode = M_OFF;
         end
         else if (!en) m_mode = M_OFF;
         else if (m_mode == M_OFF) model_enter();
         else if (m_mode == M_HI && !pwm_in) model_enter();
         else if (m_mode == M_LO && pwm_in) model_enter();
         else if (m_mode == M_DT && m_edge == m_band_end) m_mode = pwm_in ? M_HI : M_LO;
         e.irq = (m_mode == M_FAULT) && (prev != M_FAULT);
      end
      e.pwm0 = (m_mode == M_HI);
      e.pwm1 = (m_mode == M_LO);
      e.fo   = (m_mode == M_FAULT);
      e.st   = 3'(m_mode);
      exp_q.push_back(e);
   endfunction

   task automatic cycle();
      model_step();
      @(posedge clk);
      #2;
   endtask

   // Monitor: one expected record per edge, compared 1 time unit after it
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("pwm0", pwm0, e.pwm0);
            chk("pwm1", pwm1, e.pwm1);
            chk("fault_o", fault_o, e.fo);
            chk("fault_irq", fault_irq, e.irq);
            chk("state_o", state_o, e.st);
            chk("overlap", pwm0 & pwm1, 0);
         end
      end
   end

   initial begin
      int n;
      int seen;
      int hold;
      wb_rst_i = 1'b1; en = 1'b0; pwm_in = 1'b0; dead_time = 8'd0;
      fault_in = 1'b0; fault_pol = 1'b1; flt_filt = 4'd4;
      fault_clr = 1'b0; auto_restart = 1'b0;
      @(posedge clk);
      #2;
      repeat (3) cycle();
      chk("reset_state", int'({pwm0, pwm1, fault_o, fault_irq, state_o}), 0);
      wb_rst_i = 1'b0;

      // complementary drive, dead band 3, period 20
      en = 1'b1; dead_time = 8'd3;
      for (int i = 0; i < 100; i++) begin pwm_in = ((i % 20) < 10); cycle(); end

      // zero dead band
      dead_time = 8'd0;
      for (int i = 0; i < 60; i++) begin pwm_in = ((i % 8) < 4); cycle(); end

      // 2-cycle glitch inside a 5-cycle band is swallowed
      dead_time = 8'd5; pwm_in = 1'b0;
      repeat (15) cycle();
      seen = 0;
      pwm_in = 1'b1;
      repeat (2) begin cycle(); seen |= int'(pwm0); end
      pwm_in = 1'b0;
      repeat (15) begin cycle(); seen |= int'(pwm0); end
      chk("glitch_pwm0", seen, 0);
      chk("glitch_back_lo", state_o, M_LO);

      // fault filter: short pulse ignored, held pad trips after 2+4+1 edges
      fault_in = 1'b1;
      repeat (3) cycle();
      fault_in = 1'b0;
      repeat (10) cycle();
      chk("short_pulse", fault_o, 0);
      fault_in = 1'b1;
      n = 0;
      while (!fault_o && n < 20) begin cycle(); n++; end
      chk("fault_latency", n, 7);
      repeat (4) cycle();
      fault_clr = 1'b1; cycle(); fault_clr = 1'b0;
      repeat (2) cycle();
      chk("clr_while_active", fault_o, 1);
      fault_in = 1'b0;
      repeat (8) cycle();
      chk("stay_fault_no_clr", fault_o, 1);
      fault_clr = 1'b1; cycle(); fault_clr = 1'b0;
      chk("clr_exit", state_o, M_OFF);
      for (int i = 0; i < 30; i++) begin pwm_in = ((i % 12) < 6); cycle(); end

      // auto restart
      auto_restart = 1'b1; fault_in = 1'b1;
      repeat (12) cycle();
      fault_in = 1'b0;
      n = 0;
      while (fault_o && n < 20) begin cycle(); n++; end
      chk("auto_restart_exit", fault_o, 0);
      auto_restart = 1'b0;

      // reset while in HI
      dead_time = 8'd2; pwm_in = 1'b1;
      repeat (10) cycle();
      chk("in_hi", state_o, M_HI);
      wb_rst_i = 1'b1; cycle();
      chk("rst_mid_state", int'({pwm0, pwm1, state_o}), 0);
      wb_rst_i = 1'b0;

      // disable inside a band, re-enable reloads the full band
      dead_time = 8'd6;
      repeat (12) cycle();
      pwm_in = 1'b0;
      repeat (3) cycle();
      chk("in_dt", state_o, M_DT);
      en = 1'b0; cycle();
      chk("en_off", state_o, M_OFF);
      en = 1'b1; cycle();
      n = 0;
      while (state_o == 3'd1 && n < 20) begin n++; cycle(); end
      chk("reload_band", n, 6);

      // random soak
      hold = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            wb_rst_i  = 1'b1;
            flt_filt  = 4'($urandom_range(0, 6));
            fault_pol = 1'($urandom_range(0, 1));
         end else begin
            wb_rst_i = 1'b0;
         end
         if ($urandom_range(0, 99) == 0) en = ~en;
         if ($urandom_range(0, 6) == 0) pwm_in = ~pwm_in;
         if ($urandom_range(0, 49) == 0) dead_time = 8'($urandom_range(0, 7));
         if ($urandom_range(0, 49) == 0) auto_restart = ~auto_restart;
         if (hold == 0 && $urandom_range(0, 99) == 0) hold = $urandom_range(1, 12);
         if (hold > 0) begin fault_in = fault_pol; hold--; end
         else fault_in = ~fault_pol;
         fault_clr = 1'($urandom_range(0, 19) == 0);
         cycle();
      end

      @(posedge clk);
      #2;
      chk("queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
